// File: rtl/avr_pkg.sv
// Shared AVR fetch definitions: two-word opcode detection (JMP/CALL/LDS/STS)
// and the default program-counter width and reset vector.
package avr_pkg;

  localparam int          PC_W_DEFAULT      = 16;
  localparam int unsigned RESET_VEC_DEFAULT = 0;

  localparam logic [15:0] JMP_CALL_MASK  = 16'hFE0C;
  localparam logic [15:0] JMP_CALL_MATCH = 16'h940C;
  localparam logic [15:0] LDS_STS_MASK   = 16'hFC0F;
  localparam logic [15:0] LDS_STS_MATCH  = 16'h9000;

  function automatic logic is32(input logic [15:0] w);
    return ((w & JMP_CALL_MASK) == JMP_CALL_MATCH) ||
           ((w & LDS_STS_MASK) == LDS_STS_MATCH);
  endfunction

endpackage

// File: rtl/avr_fetch_queue.sv
// DEPTH-word circular FIFO for the fetch unit: push-1, pop-0/1/2, synchronous
// flush, with the head and head+1 words exposed for two-word decode.
module avr_fetch_queue #(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          push,
  input  logic [15:0]   push_data,
  input  logic [1:0]    pop,
  output logic [15:0]   head,
  output logic [15:0]   head_nxt,
  output logic [CW-1:0] count
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;

  // Modulo-DEPTH pointer advance; a single subtraction suffices since k <= 2 <= DEPTH.
  function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [1:0] k);
    logic [AW:0] s;
    s = (AW+1)'(p) + (AW+1)'(k);
    if (s >= (AW+1)'(DEPTH)) s = s - (AW+1)'(DEPTH);
    return s[AW-1:0];
  endfunction

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_add(wr_ptr_reg, 2'd1);
      rd_ptr_reg <= ptr_add(rd_ptr_reg, pop);
      count_reg  <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !flush && !RST) mem[wr_ptr_reg] <= push_data;
  end

  assign head     = mem[rd_ptr_reg];
  assign head_nxt = mem[ptr_add(rd_ptr_reg, 2'd1)];
  assign count    = count_reg;

endmodule

// File: rtl/avr_fetch_pq.sv
// Prefetching AVR instruction-fetch unit: DEPTH-word queue, 16/32-bit decode,
// redirect flush. Skip semantics are built only when AVR_FETCH_SKIP_EN is defined.
module avr_fetch_pq
  import avr_pkg::*;
#(
  parameter int          PC_W      = PC_W_DEFAULT,
  parameter int          DEPTH     = 4,
  parameter int unsigned RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            prog_rd,
  output logic [PC_W-1:0] prog_addr,
  input  logic [15:0]     prog_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [15:0]     instr,
  output logic [15:0]     instr_ext,
  output logic            instr_is32,
  output logic [PC_W-1:0] instr_pc,
  input  logic            redir_valid,
  input  logic            redir_rel,
  input  logic [PC_W-1:0] redir_tgt,
  input  logic            skip_req
);

  localparam int              CW     = $clog2(DEPTH + 1);
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_VEC);

  logic [PC_W-1:0] fetch_pc_reg, instr_pc_reg, redir_pc;
  logic            inflight_reg;
  logic [CW-1:0]   occ;
  logic [CW:0]     pending;
  logic [15:0]     head_word, head_nxt;
  logic [1:0]      head_len, pop_cnt;
  logic            head_is32, head_complete, accept, redir_take;
  logic            skip_pend, skip_pop, pop_any;

  avr_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (redir_take),
    .push      (inflight_reg),
    .push_data (prog_data),
    .pop       (pop_cnt),
    .head      (head_word),
    .head_nxt  (head_nxt),
    .count     (occ)
  );

  assign head_is32     = is32(head_word);
  assign head_len      = head_is32 ? 2'd2 : 2'd1;
  assign head_complete = (occ >= CW'(head_len));
  assign instr_valid   = head_complete & ~skip_pend;
  assign accept        = instr_valid & instr_ready;

  // Relative redirects are only meaningful against a presented head.
  assign redir_take = redir_valid & (~redir_rel | instr_valid);
  assign redir_pc   = redir_rel ? instr_pc_reg + PC_W'(head_len) + redir_tgt : redir_tgt;

  assign pop_any = ~redir_take & (accept | skip_pop);
  assign pop_cnt = pop_any ? head_len : 2'd0;

  assign pending = (CW+1)'(occ) + (CW+1)'(inflight_reg);
  assign prog_rd = ~RST & ~redir_take & (pending < (CW+1)'(DEPTH));

  assign prog_addr  = fetch_pc_reg;
  assign instr_pc   = instr_pc_reg;
  assign instr      = instr_valid ? head_word : 16'h0000;
  assign instr_is32 = instr_valid & head_is32;
  assign instr_ext  = instr_is32 ? head_nxt : 16'h0000;

  // A word returning during a redirect is dropped by the queue flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_reg <= RST_PC;
      instr_pc_reg <= RST_PC;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= prog_rd;
      if (redir_take) begin
        fetch_pc_reg <= redir_pc;
        instr_pc_reg <= redir_pc;
      end else begin
        if (prog_rd) fetch_pc_reg <= fetch_pc_reg + PC_W'(1);
        if (pop_any) instr_pc_reg <= instr_pc_reg + PC_W'(head_len);
      end
    end
  end

`ifdef AVR_FETCH_SKIP_EN
  logic skip_pend_reg;

  always_ff @(posedge CLK) begin
    if (RST || redir_take)      skip_pend_reg <= 1'b0;
    else if (accept && skip_req) skip_pend_reg <= 1'b1;
    else if (skip_pop)           skip_pend_reg <= 1'b0;
  end

  assign skip_pend = skip_pend_reg;
  assign skip_pop  = skip_pend_reg & head_complete;
`else
  logic unused_skip_req;
  assign unused_skip_req = skip_req;
  assign skip_pend       = 1'b0;
  assign skip_pop        = 1'b0;
`endif

endmodule

// File: tb/tb_avr_fetch_pq.sv
// Directed table-driven bench for avr_fetch_pq with a synchronous ROM model.
module tb_avr_fetch_pq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        prog_rd;
  logic [15:0] prog_addr;
  logic [15:0] rom_q;
  logic        instr_valid, instr_ready, instr_is32;
  logic [15:0] instr, instr_ext, instr_pc;
  logic        redir_valid, redir_rel, skip_req;
  logic [15:0] redir_tgt;

  always #5 CLK = ~CLK;

  avr_fetch_pq dut (
    .CLK         (CLK),
    .RST         (RST),
    .prog_rd     (prog_rd),
    .prog_addr   (prog_addr),
    .prog_data   (rom_q),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_ext   (instr_ext),
    .instr_is32  (instr_is32),
    .instr_pc    (instr_pc),
    .redir_valid (redir_valid),
    .redir_rel   (redir_rel),
    .redir_tgt   (redir_tgt),
    .skip_req    (skip_req)
  );

  logic [15:0] rom [65536];
  always @(posedge CLK) if (prog_rd) rom_q <= rom[prog_addr];

  typedef struct {
    logic        rst, rdy, rv, rrel;
    logic [15:0] rtgt;
    logic        ev;
    logic [15:0] epc;
    logic        cd;
    logic [15:0] ei, ee;
    logic        e32;
    logic        erd;
    logic [15:0] ea;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rv, input logic rrel,
                              input logic [15:0] rtgt, input logic ev, input logic [15:0] epc,
                              input logic cd, input logic [15:0] ei, input logic [15:0] ee,
                              input logic e32, input logic erd, input logic [15:0] ea);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rrel = rrel; v.rtgt = rtgt;
    v.ev = ev; v.epc = epc; v.cd = cd | ev; v.ei = ei; v.ee = ee; v.e32 = e32;
    v.erd = erd; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    logic got;
    for (int i = 0; i < 65536; i++) rom[i] = 16'h1000 | 16'(i & 32'h0FFF);
    rom[16'h0020] = 16'h940C; rom[16'h0021] = 16'h1234;
    rom[16'h0041] = 16'h9000; rom[16'h0042] = 16'h0100;

    // rst rdy rv rrel tgt | ev pc | cd instr ext is32 | rd addr
    tbl.push_back(mk(1,1,0,0,16'h0, 0,16'h0000, 1,16'h0,16'h0,0, 0,16'h0000));
    tbl.push_back(mk(0,1,0,0,16'h0, 0,16'h0000, 0,16'h0,16'h0,0, 1,16'h0000));
    tbl.push_back(mk(0,1,0,0,16'h0, 0,16'h0000, 0,16'h0,16'h0,0, 1,16'h0001));
    for (int p = 0; p < 4; p++)
      tbl.push_back(mk(0,1,0,0,16'h0, 1,16'(p), 0,16'(16'h1000 + p),16'h0,0, 1,16'(p + 2)));
    tbl.push_back(mk(0,0,0,0,16'h0, 1,16'h0004, 0,16'h1004,16'h0,0, 1,16'h0006));
    tbl.push_back(mk(0,0,0,0,16'h0, 1,16'h0004, 0,16'h1004,16'h0,0, 1,16'h0007));
    for (int r = 0; r < 8; r++)
      tbl.push_back(mk(0,0,0,0,16'h0, 1,16'h0004, 0,16'h1004,16'h0,0, 0,16'h0008));
    tbl.push_back(mk(0,1,0,0,16'h0, 1,16'h0004, 0,16'h1004,16'h0,0, 0,16'h0008));
    for (int p = 5; p < 9; p++)
      tbl.push_back(mk(0,1,0,0,16'h0, 1,16'(p), 0,16'(16'h1000 + p),16'h0,0, 1,16'(p + 3)));
    tbl.push_back(mk(0,1,1,1,16'hFFFD, 1,16'h0009, 0,16'h1009,16'h0,0, 0,16'h000C));
    tbl.push_back(mk(0,1,0,0,16'h0, 0,16'h0007, 0,16'h0,16'h0,0, 1,16'h0007));
    tbl.push_back(mk(0,1,1,1,16'h0005, 0,16'h0007, 0,16'h0,16'h0,0, 1,16'h0008));
    tbl.push_back(mk(0,1,0,0,16'h0, 1,16'h0007, 0,16'h1007,16'h0,0, 1,16'h0009));
    tbl.push_back(mk(0,1,0,0,16'h0, 1,16'h0008, 0,16'h1008,16'h0,0, 1,16'h000A));
    tbl.push_back(mk(0,1,1,0,16'h0020, 1,16'h0009, 0,16'h1009,16'h0,0, 0,16'h000B));
    tbl.push_back(mk(0,1,0,0,16'h0, 0,16'h0020, 0,16'h0,16'h0,0, 1,16'h0020));
    tbl.push_back(mk(0,1,0,0,16'h0, 0,16'h0020, 0,16'h0,16'h0,0, 1,16'h0021));
    tbl.push_back(mk(0,1,0,0,16'h0, 0,16'h0020, 0,16'h0,16'h0,0, 1,16'h0022));
    tbl.push_back(mk(0,1,0,0,16'h0, 1,16'h0020, 0,16'h940C,16'h1234,1, 1,16'h0023));
    tbl.push_back(mk(0,1,0,0,16'h0, 1,16'h0022, 0,16'h1022,16'h0,0, 1,16'h0024));
    tbl.push_back(mk(0,0,1,0,16'hFFFF, 1,16'h0023, 0,16'h1023,16'h0,0, 0,16'h0025));
    tbl.push_back(mk(0,1,0,0,16'h0, 0,16'hFFFF, 0,16'h0,16'h0,0, 1,16'hFFFF));
    tbl.push_back(mk(0,1,0,0,16'h0, 0,16'hFFFF, 0,16'h0,16'h0,0, 1,16'h0000));
    tbl.push_back(mk(0,1,0,0,16'h0, 1,16'hFFFF, 0,16'h1FFF,16'h0,0, 1,16'h0001));
    tbl.push_back(mk(0,1,0,0,16'h0, 1,16'h0000, 0,16'h1000,16'h0,0, 1,16'h0002));
    tbl.push_back(mk(1,1,0,0,16'h0, 1,16'h0001, 0,16'h1001,16'h0,0, 0,16'h0003));
    tbl.push_back(mk(0,1,0,0,16'h0, 0,16'h0000, 1,16'h0,16'h0,0, 1,16'h0000));
    tbl.push_back(mk(0,1,0,0,16'h0, 0,16'h0000, 0,16'h0,16'h0,0, 1,16'h0001));
    tbl.push_back(mk(0,1,0,0,16'h0, 1,16'h0000, 0,16'h1000,16'h0,0, 1,16'h0002));

    RST = 1'b1; instr_ready = 1'b0; redir_valid = 1'b0; redir_rel = 1'b0;
    redir_tgt = 16'h0; skip_req = 1'b0;
    repeat (2) @(posedge CLK);

    foreach (tbl[i]) begin
      @(negedge CLK);
      RST = tbl[i].rst; instr_ready = tbl[i].rdy; redir_valid = tbl[i].rv;
      redir_rel = tbl[i].rrel; redir_tgt = tbl[i].rtgt; skip_req = 1'b0;
      #1;
      chk("instr_valid", i, 32'(instr_valid), 32'(tbl[i].ev));
      chk("instr_pc",    i, 32'(instr_pc),    32'(tbl[i].epc));
      chk("prog_rd",     i, 32'(prog_rd),     32'(tbl[i].erd));
      chk("prog_addr",   i, 32'(prog_addr),   32'(tbl[i].ea));
      if (tbl[i].cd) begin
        chk("instr",      i, 32'(instr),      32'(tbl[i].ei));
        chk("instr_ext",  i, 32'(instr_ext),  32'(tbl[i].ee));
        chk("instr_is32", i, 32'(instr_is32), 32'(tbl[i].e32));
      end
      $display("row %0d: valid=%0d pc=%h instr=%h ext=%h is32=%0d rd=%0d addr=%h",
               i, instr_valid, instr_pc, instr, instr_ext, instr_is32, prog_rd, prog_addr);
    end

    // Redirect to 0x40 with skip_req held: skip must lose to the redirect and
    // be ignored while nothing is presented, then act on the accept of 0x40.
    @(negedge CLK);
    RST = 1'b0; instr_ready = 1'b1; redir_valid = 1'b1; redir_rel = 1'b0;
    redir_tgt = 16'h0040; skip_req = 1'b1;
    @(negedge CLK);
    redir_valid = 1'b0;
    #1;
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (instr_valid) begin got = 1'b1; break; end
      @(negedge CLK); #1;
    end
    chk("skip_first_valid", 100, 32'(got), 32'd1);
    chk("skip_first_pc",    100, 32'(instr_pc), 32'h0040);
    $display("seq skip: accept pc=%h instr=%h skip_req=%0d", instr_pc, instr, skip_req);
    @(negedge CLK);
    skip_req = 1'b0;
    #1;
    got = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (instr_valid) begin got = 1'b1; break; end
      @(negedge CLK); #1;
    end
    chk("skip_next_valid", 101, 32'(got), 32'd1);
`ifdef AVR_FETCH_SKIP_EN
    chk("skip_next_pc",    101, 32'(instr_pc), 32'h0043);
    chk("skip_next_instr", 101, 32'(instr),    32'h1043);
`else
    chk("skip_next_pc",    101, 32'(instr_pc),   32'h0041);
    chk("skip_next_instr", 101, 32'(instr),      32'h9000);
    chk("skip_next_ext",   101, 32'(instr_ext),  32'h0100);
    chk("skip_next_is32",  101, 32'(instr_is32), 32'd1);
`endif
    $display("seq skip: next pc=%h instr=%h ext=%h is32=%0d", instr_pc, instr, instr_ext, instr_is32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
